approx_mac_acc: RTL and testbench

- Downstream accumulation stage for the 16x16 approximate log multiplier. It consumes that multiplier's 32-bit signed product stream through a valid/ready handshake.
- Sums each group of LEN consecutive products into a wide accumulator, then presents one 32-bit dot-product result per group on a registered valid/ready output.
- Sits between the multiplier (registered-input wrapper) and the result writeback/FIFO of the approximate MAC datapath.

---
 rtl/approx_mac_acc_if.sv | 21 ++
 rtl/approx_mac_acc.sv | 121 ++++++++++++
 tb/tb_approx_mac_acc.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_mac_acc_if.sv
// Product-in / result-out handshake bundle for the approximate MAC accumulator.
// slave is the accumulator side; master is the producer/consumer side.
interface approx_mac_acc_if;
    logic [31:0] prod_i;
    logic        prod_valid_i;
    logic        prod_ready_o;
    logic [31:0] res_o;
    logic        res_valid_o;
    logic        res_ready_i;
    logic        sat_o;

    modport slave (
        input  prod_i, prod_valid_i, res_ready_i,
        output prod_ready_o, res_o, res_valid_o, sat_o
    );

    modport master (
        output prod_i, prod_valid_i, res_ready_i,
        input  prod_ready_o, res_o, res_valid_o, sat_o
    );
endinterface

// File: rtl/approx_mac_acc.sv
// Sums groups of LEN signed products into one 32-bit result per group.
// Define APPROX_MAC_SAT_EN to clip results to the int32 range; otherwise they wrap.
module approx_mac_acc #(
    parameter int LEN   = 16,
    parameter int ACC_W = 40
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    approx_mac_acc_if.slave        bus,
    output logic [7:0]             cnt_o
);

    localparam logic [7:0] LAST_CNT = 8'(LEN - 1);

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    state_t                   r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic [7:0]               r_cnt;
    logic [31:0]              r_res;
    logic                     r_res_valid;
    logic                     r_sat;

    logic signed [ACC_W-1:0]  w_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic [31:0]              w_res;
    logic                     w_sat;
    logic                     w_acc_ev;
    logic                     w_res_ev;

    // In OUT a new product is only taken when the pending result drains the same cycle.
    assign bus.prod_ready_o = !clr_i && ((r_state == ST_ACC) || bus.res_ready_i);
    assign w_acc_ev         = bus.prod_valid_i && bus.prod_ready_o;
    assign w_res_ev         = r_res_valid && bus.res_ready_i;

    assign w_ext = ACC_W'($signed(bus.prod_i));
    assign w_sum = r_acc + w_ext;

`ifdef APPROX_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sh7FFF_FFFF);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(32'sh8000_0000);

    always_comb begin
        w_res = w_sum[31:0];
        w_sat = 1'b0;
        if (w_sum > SAT_MAX) begin
            w_res = 32'h7FFF_FFFF;
            w_sat = 1'b1;
        end else if (w_sum < SAT_MIN) begin
            w_res = 32'h8000_0000;
            w_sat = 1'b1;
        end
    end
`else
    assign w_res = w_sum[31:0];
    assign w_sat = 1'b0;
`endif

    // Accumulator is always zero in OUT, so w_sum there is just the new product.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_ACC;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_sat       <= 1'b0;
        end else if (clr_i) begin
            r_state     <= ST_ACC;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_acc_ev) begin
                        if (r_cnt == LAST_CNT) begin
                            r_res       <= w_res;
                            r_sat       <= w_sat;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_res_valid <= 1'b1;
                            r_state     <= ST_OUT;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                ST_OUT: begin
                    if (w_res_ev) begin
                        if (w_acc_ev && (LEN == 1)) begin
                            r_res <= w_res;
                            r_sat <= w_sat;
                        end else if (w_acc_ev) begin
                            r_acc       <= w_ext;
                            r_cnt       <= 8'd1;
                            r_res_valid <= 1'b0;
                            r_state     <= ST_ACC;
                        end else begin
                            r_res_valid <= 1'b0;
                            r_state     <= ST_ACC;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_ACC;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.res_o       = r_res;
    assign bus.res_valid_o = r_res_valid;
    assign bus.sat_o       = r_sat;
    assign cnt_o           = r_cnt;

endmodule

// File: tb/tb_approx_mac_acc.sv
// Scoreboard bench for approx_mac_acc: a LEN=4 instance for the directed groups
// and a LEN=2 instance for back-to-back streaming.
module tb_approx_mac_acc;

    typedef struct {
        logic [31:0] res;
        logic        sat;
    } exp_t;

    localparam longint MAX_L = 64'sh7FFF_FFFF;
    localparam longint MIN_L = -64'sh8000_0000;

    logic       clk;
    logic       rstN;
    logic       clr;
    logic [7:0] cnt4;
    logic [7:0] cnt2;

    approx_mac_acc_if bus4 ();
    approx_mac_acc_if bus2 ();

    approx_mac_acc #(.LEN(4), .ACC_W(40)) dut4 (
        .clk_i(clk), .rst_ni(rstN), .clr_i(clr), .bus(bus4.slave), .cnt_o(cnt4)
    );

    approx_mac_acc #(.LEN(2), .ACC_W(40)) dut2 (
        .clk_i(clk), .rst_ni(rstN), .clr_i(1'b0), .bus(bus2.slave), .cnt_o(cnt2)
    );

    int     checks = 0;
    int     errors = 0;
    exp_t   sb4[$];
    exp_t   sb2[$];
    longint modelAcc = 0;
    int     modelCnt = 0;
    logic [31:0] heldRes;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Golden group result straight from the arithmetic definition.
    function automatic exp_t groupResult(input longint s);
        exp_t r;
        r.res = s[31:0];
        r.sat = 1'b0;
`ifdef APPROX_MAC_SAT_EN
        if (s > MAX_L) begin
            r.res = 32'h7FFF_FFFF;
            r.sat = 1'b1;
        end else if (s < MIN_L) begin
            r.res = 32'h8000_0000;
            r.sat = 1'b1;
        end
`endif
        return r;
    endfunction

    // Offers one product to dut4, waits for acceptance and updates the model.
    task automatic applyStimulus(input logic [31:0] v);
        logic taken;
        bus4.prod_i       = v;
        bus4.prod_valid_i = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            taken = bus4.prod_ready_o;
            @(posedge clk);
            #1;
            if (taken) begin
                modelAcc += longint'($signed(v));
                modelCnt++;
                if (modelCnt == 4) begin
                    sb4.push_back(groupResult(modelAcc));
                    modelAcc = 0;
                    modelCnt = 0;
                end
                return;
            end
        end
        checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic runGroup(input logic [31:0] a, b, c, d);
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(c);
        applyStimulus(d);
        bus4.prod_valid_i = 1'b0;
    endtask

    // Results are compared as they drain on the handshake.
    always @(negedge clk) begin
        if (bus4.res_valid_o && bus4.res_ready_i) begin
            if (sb4.size() == 0) begin
                checkOutput("dut4_unexpected_res", 64'(bus4.res_o), 64'hDEAD);
            end else begin
                checkOutput("dut4_res", 64'(bus4.res_o), 64'(sb4[0].res));
                checkOutput("dut4_sat", 64'(bus4.sat_o), 64'(sb4[0].sat));
                void'(sb4.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (bus2.res_valid_o && bus2.res_ready_i) begin
            if (sb2.size() == 0) begin
                checkOutput("dut2_unexpected_res", 64'(bus2.res_o), 64'hDEAD);
            end else begin
                checkOutput("dut2_res", 64'(bus2.res_o), 64'(sb2[0].res));
                void'(sb2.pop_front());
            end
        end
    end

    initial begin
        rstN              = 1'b0;
        clr               = 1'b0;
        bus4.prod_i       = '0;
        bus4.prod_valid_i = 1'b0;
        bus4.res_ready_i  = 1'b1;
        bus2.prod_i       = '0;
        bus2.prod_valid_i = 1'b0;
        bus2.res_ready_i  = 1'b1;

        #3;
        checkOutput("rst_res", 64'(bus4.res_o), 64'd0);
        checkOutput("rst_valid", 64'(bus4.res_valid_o), 64'd0);
        checkOutput("rst_sat", 64'(bus4.sat_o), 64'd0);
        checkOutput("rst_cnt", 64'(cnt4), 64'd0);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;

        $display("[TB] basic sum");
        runGroup(32'd100, 32'd200, 32'd300, 32'd400);
        checkOutput("latency_valid", 64'(bus4.res_valid_o), 64'd1);
        checkOutput("basic_res_direct", 64'(bus4.res_o), 64'h3E8);

        $display("[TB] signed products");
        applyStimulus(32'hFFFF_FF9C);
        checkOutput("cnt_1", 64'(cnt4), 64'd1);
        applyStimulus(32'hFFFF_FF9C);
        checkOutput("cnt_2", 64'(cnt4), 64'd2);
        applyStimulus(32'hFFFF_FF9C);
        checkOutput("cnt_3", 64'(cnt4), 64'd3);
        applyStimulus(32'hFFFF_FF9C);
        checkOutput("cnt_wrap", 64'(cnt4), 64'd0);
        checkOutput("signed_res_direct", 64'(bus4.res_o), 64'hFFFF_FE70);
        bus4.prod_valid_i = 1'b0;
        @(posedge clk); #1;

        $display("[TB] backpressure");
        bus4.res_ready_i = 1'b0;
        runGroup(32'd1, 32'd2, 32'd3, 32'd4);
        heldRes           = bus4.res_o;
        checkOutput("bp_res_direct", 64'(heldRes), 64'd10);
        bus4.prod_i       = 32'd7;
        bus4.prod_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_ready_low", 64'(bus4.prod_ready_o), 64'd0);
            checkOutput("bp_valid_high", 64'(bus4.res_valid_o), 64'd1);
            checkOutput("bp_res_stable", 64'(bus4.res_o), 64'(heldRes));
            @(posedge clk); #1;
        end
        bus4.res_ready_i = 1'b1;
        applyStimulus(32'd7);
        checkOutput("bp_cnt_after_drain", 64'(cnt4), 64'd1);
        applyStimulus(32'd1);
        applyStimulus(32'd2);
        applyStimulus(32'd3);
        bus4.prod_valid_i = 1'b0;
        checkOutput("bp_next_group", 64'(bus4.res_o), 64'd13);
        @(posedge clk); #1;

        $display("[TB] saturation");
        runGroup(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        @(posedge clk); #1;
        runGroup(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        @(posedge clk); #1;

        $display("[TB] synchronous clear");
        applyStimulus(32'd10);
        applyStimulus(32'd20);
        bus4.prod_i = 32'd99;
        clr         = 1'b1;
        @(negedge clk);
        checkOutput("clr_ready_low", 64'(bus4.prod_ready_o), 64'd0);
        @(posedge clk); #1;
        clr               = 1'b0;
        bus4.prod_valid_i = 1'b0;
        modelAcc          = 0;
        modelCnt          = 0;
        checkOutput("clr_cnt", 64'(cnt4), 64'd0);
        runGroup(32'd1, 32'd2, 32'd3, 32'd4);
        @(posedge clk); #1;

        $display("[TB] async reset mid-group");
        applyStimulus(32'd10);
        applyStimulus(32'd20);
        bus4.prod_valid_i = 1'b0;
        rstN = 1'b0;
        #1;
        checkOutput("arst_res", 64'(bus4.res_o), 64'd0);
        checkOutput("arst_valid", 64'(bus4.res_valid_o), 64'd0);
        checkOutput("arst_cnt", 64'(cnt4), 64'd0);
        @(posedge clk); #1;
        rstN     = 1'b1;
        modelAcc = 0;
        modelCnt = 0;
        sb4.delete();
        runGroup(32'd5, 32'd6, 32'd7, 32'd8);
        checkOutput("arst_next_group", 64'(bus4.res_o), 64'd26);
        @(posedge clk); #1;

        $display("[TB] streaming LEN=2");
        sb2.push_back('{32'd3, 1'b0});
        sb2.push_back('{32'd7, 1'b0});
        sb2.push_back('{32'd11, 1'b0});
        for (int i = 1; i <= 6; i++) begin
            bus2.prod_i       = 32'(i);
            bus2.prod_valid_i = 1'b1;
            @(negedge clk);
            checkOutput("strm_ready", 64'(bus2.prod_ready_o), 64'd1);
            @(posedge clk); #1;
        end
        bus2.prod_valid_i = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        checkOutput("sb4_drained", 64'(sb4.size()), 64'd0);
        checkOutput("sb2_drained", 64'(sb2.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
